// File: rtl/ram_port_pkg.sv
// ram_port_pkg: shared types and helpers for the RAM port controller.
//   size_e   - request size encoding (byte / halfword / word / reserved)
//   state_e  - controller sequencing states
//   is_misaligned() - flags reserved sizes and addresses not aligned to the size
package ram_port_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned LANE_W = 2;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_e;

    // A request errors out if its size is reserved or its byte offset is not size-aligned.
    function automatic logic is_misaligned(input size_e size, input logic [LANE_W-1:0] lane);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ram_lane_unit.sv
// ram_lane_unit: combinational byte-lane logic for little-endian sub-word access.
//   i_rdata        - word read from the RAM
//   i_wdata        - store data, right-justified
//   i_size         - access size
//   i_lane         - byte offset within the word
//   i_signed       - sign-extend loads when set
//   o_load_val     - selected lane, extended to a full word
//   o_merged_word  - i_rdata with the selected lane replaced by i_wdata's low bits
module ram_lane_unit
    import ram_port_pkg::*;
(
    input  logic [WORD_W-1:0] i_rdata,
    input  logic [WORD_W-1:0] i_wdata,
    input  size_e             i_size,
    input  logic [LANE_W-1:0] i_lane,
    input  logic              i_signed,
    output logic [WORD_W-1:0] o_load_val,
    output logic [WORD_W-1:0] o_merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane extraction and merge.
    always_comb begin
        w_byte        = 8'(i_rdata >> {i_lane, 3'b000});
        w_half        = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_load_val    = i_rdata;
        o_merged_word = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_load_val    = {{24{i_signed & w_byte[7]}}, w_byte};
                o_merged_word = i_rdata;
                case (i_lane)
                    2'd0: o_merged_word[7:0]   = i_wdata[7:0];
                    2'd1: o_merged_word[15:8]  = i_wdata[7:0];
                    2'd2: o_merged_word[23:16] = i_wdata[7:0];
                    2'd3: o_merged_word[31:24] = i_wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                o_load_val    = {{16{i_signed & w_half[15]}}, w_half};
                o_merged_word = i_rdata;
                if (i_lane[1]) begin
                    o_merged_word[31:16] = i_wdata[15:0];
                end else begin
                    o_merged_word[15:0]  = i_wdata[15:0];
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/ram_port_ctrl.sv
// ram_port_ctrl: initiator-side controller for the single-port data RAM.
//   i_clk, i_rst                 - clock, synchronous active-high reset
//   i_req_* / o_req_ready        - load/store request channel (valid/ready)
//   o_rsp_valid/err/rdata        - one-cycle completion pulse with load data
//   o_ram_ena, o_wena, o_addr,
//   o_data_in, i_data_out        - RAM pins (read data valid the cycle after a read)
// Sub-word stores are done as read-modify-write. RAM pins and response outputs are
// decoded from the registered state and latched fields, and forced low during reset.
module ram_port_ctrl
    import ram_port_pkg::*;
#(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_signed,
    input  logic [ADDR_W+1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic              o_rsp_err,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_ram_ena,
    output logic              o_wena,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data_in,
    input  logic [DATA_W-1:0] i_data_out
);

    state_e              r_state;
    logic                r_we;
    size_e               r_size;
    logic                r_signed;
    logic [LANE_W-1:0]   r_lane;
    logic [ADDR_W-1:0]   r_waddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_word;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic [DATA_W-1:0]   w_load_val;
    logic [DATA_W-1:0]   w_merged_word;
    size_e               w_req_size;
    logic [LANE_W-1:0]   w_req_lane;
    logic                w_active;

    assign w_req_size = size_e'(i_req_size);
    assign w_req_lane = i_req_addr[1:0];
    assign w_active   = ~i_rst;

    // Lane logic sees live RAM read data; its outputs are only consumed in CAP.
    ram_lane_unit u_lane (
        .i_rdata       (i_data_out),
        .i_wdata       (r_wdata),
        .i_size        (r_size),
        .i_lane        (r_lane),
        .i_signed      (r_signed),
        .o_load_val    (w_load_val),
        .o_merged_word (w_merged_word)
    );

    // Sequencer: latches the request at acceptance and walks RD/CAP/WR/RESP.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_we     <= 1'b0;
            r_size   <= SZ_BYTE;
            r_signed <= 1'b0;
            r_lane   <= '0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_word   <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req_valid) begin
                        r_we     <= i_req_we;
                        r_size   <= w_req_size;
                        r_signed <= i_req_signed;
                        r_lane   <= w_req_lane;
                        r_waddr  <= i_req_addr[ADDR_W+1:2];
                        r_wdata  <= i_req_wdata;
                        r_word   <= i_req_wdata;
                        r_rdata  <= '0;
                        if (is_misaligned(w_req_size, w_req_lane)) begin
                            r_err   <= 1'b1;
                            r_state <= RESP;
                        end else if (i_req_we && (w_req_size == SZ_WORD)) begin
                            r_err   <= 1'b0;
                            r_state <= WR;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= RD;
                        end
                    end
                end
                RD: begin
                    r_state <= CAP;
                end
                CAP: begin
                    // Stores keep the merged word for WR; loads keep the extracted value.
                    if (r_we) begin
                        r_word  <= w_merged_word;
                        r_state <= WR;
                    end else begin
                        r_rdata <= w_load_val;
                        r_state <= RESP;
                    end
                end
                WR: begin
                    r_state <= RESP;
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Reset gating here also suppresses a WR that coincides with reset.
    assign o_req_ready = w_active && (r_state == IDLE);
    assign o_ram_ena   = w_active && ((r_state == RD) || (r_state == WR));
    assign o_wena      = w_active && (r_state == WR);
    assign o_addr      = (w_active && (r_state != IDLE)) ? r_waddr : '0;
    assign o_data_in   = o_wena ? r_word : '0;

    assign o_rsp_valid = w_active && (r_state == RESP);
    assign o_rsp_err   = o_rsp_valid && r_err;
    assign o_rsp_rdata = o_rsp_valid ? r_rdata : '0;

endmodule

// File: tb/tb_ram_port_ctrl.sv
module tb_ram_port_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        ram_ena;
    logic        wena;
    logic [4:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    logic [31:0] mem [32];
    logic        pre_we;
    logic [4:0]  pre_addr;
    logic [31:0] pre_data;
    int          n_wr;
    int          n_rd;

    int n_tests;
    int n_fail;

    ram_port_ctrl #(.ADDR_W(5), .DATA_W(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_size   (req_size),
        .i_req_signed (req_signed),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_err    (rsp_err),
        .o_rsp_rdata  (rsp_rdata),
        .o_ram_ena    (ram_ena),
        .o_wena       (wena),
        .o_addr       (addr),
        .o_data_in    (data_in),
        .i_data_out   (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, registered read; preload port for the bench.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_ena && wena) begin
            mem[addr] <= data_in;
            n_wr      <= n_wr + 1;
        end else if (ram_ena) begin
            data_out <= mem[addr];
            n_rd     <= n_rd + 1;
        end
    end

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [6:0] a, input logic [31:0] wd,
                          output int lat, output logic err, output logic [31:0] rd,
                          output int n_ena);
        int w;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1; err = 1'b0; rd = 32'hxxxx_xxxx; n_ena = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ram_ena) n_ena++;
            if (rsp_valid) begin
                lat = c; err = rsp_err; rd = rsp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b0 || ram_ena !== 1'b0 || wena !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ready=%b ena=%b wena=%b rsp_valid=%b rsp_err=%b, expected all 0",
                     req_ready, ram_ena, wena, rsp_valid, rsp_err);
        end
        n_tests++;
        if (addr !== 5'd0 || data_in !== 32'd0 || rsp_rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h data_in=%h rdata=%h, expected 0", addr, data_in, rsp_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_word_store_load();
        int lat; logic err; logic [31:0] rd; int ne;
        do_req(1'b1, 2'b10, 1'b0, 7'h08, 32'hDEAD_BEEF, lat, err, rd, ne);
        n_tests++;
        if (lat !== 2 || err !== 1'b0 || rd !== 32'd0) begin
            n_fail++;
            $display("FAIL word_store: lat=%0d err=%b rdata=%h, expected lat=2 err=0 rdata=0", lat, err, rd);
        end
        n_tests++;
        if (mem[2] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL word_store_ram: RAM[2]=%h expected deadbeef", mem[2]);
        end
        do_req(1'b0, 2'b10, 1'b0, 7'h08, 32'd0, lat, err, rd, ne);
        n_tests++;
        if (lat !== 3 || err !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL word_load: lat=%0d err=%b rdata=%h, expected lat=3 err=0 rdata=deadbeef", lat, err, rd);
        end
    endtask

    task automatic test_byte_rmw();
        int lat; logic err; logic [31:0] rd; int ne; int rd0; int wr0;
        preload(5'd3, 32'h1122_3344);
        rd0 = n_rd; wr0 = n_wr;
        do_req(1'b1, 2'b00, 1'b0, 7'h0E, 32'h0000_00AB, lat, err, rd, ne);
        n_tests++;
        if (lat !== 4 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL byte_rmw_lat: lat=%0d err=%b, expected lat=4 err=0", lat, err);
        end
        n_tests++;
        if (mem[3] !== 32'h11AB_3344) begin
            n_fail++;
            $display("FAIL byte_rmw_ram: RAM[3]=%h expected 11ab3344", mem[3]);
        end
        n_tests++;
        if (n_rd - rd0 !== 1 || n_wr - wr0 !== 1) begin
            n_fail++;
            $display("FAIL byte_rmw_ops: reads=%0d writes=%0d, expected 1 and 1", n_rd - rd0, n_wr - wr0);
        end
        do_req(1'b1, 2'b01, 1'b0, 7'h0E, 32'h1234_CAFE, lat, err, rd, ne);
        n_tests++;
        if (lat !== 4 || mem[3] !== 32'hCAFE_3344) begin
            n_fail++;
            $display("FAIL half_rmw: lat=%0d RAM[3]=%h, expected lat=4 cafe3344", lat, mem[3]);
        end
    endtask

    task automatic test_sub_loads();
        int lat; logic err; logic [31:0] rd; int ne;
        preload(5'd1, 32'h8001_7FFF);
        do_req(1'b0, 2'b01, 1'b1, 7'h06, 32'd0, lat, err, rd, ne);
        n_tests++;
        if (lat !== 3 || rd !== 32'hFFFF_8001) begin
            n_fail++;
            $display("FAIL half_load_signed: lat=%0d rdata=%h, expected 3 ffff8001", lat, rd);
        end
        do_req(1'b0, 2'b01, 1'b0, 7'h06, 32'd0, lat, err, rd, ne);
        n_tests++;
        if (rd !== 32'h0000_8001) begin
            n_fail++;
            $display("FAIL half_load_unsigned: rdata=%h expected 00008001", rd);
        end
        do_req(1'b0, 2'b00, 1'b1, 7'h04, 32'd0, lat, err, rd, ne);
        n_tests++;
        if (rd !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL byte_load_lane0_signed: rdata=%h expected ffffffff", rd);
        end
        do_req(1'b0, 2'b00, 1'b0, 7'h05, 32'd0, lat, err, rd, ne);
        n_tests++;
        if (rd !== 32'h0000_007F) begin
            n_fail++;
            $display("FAIL byte_load_lane1_unsigned: rdata=%h expected 0000007f", rd);
        end
        do_req(1'b0, 2'b00, 1'b1, 7'h07, 32'd0, lat, err, rd, ne);
        n_tests++;
        if (rd !== 32'hFFFF_FF80) begin
            n_fail++;
            $display("FAIL byte_load_lane3_signed: rdata=%h expected ffffff80", rd);
        end
    endtask

    task automatic test_misaligned();
        int lat; logic err; logic [31:0] rd; int ne; int wr0;
        preload(5'd0, 32'h0BAD_F00D);
        wr0 = n_wr;
        do_req(1'b0, 2'b10, 1'b0, 7'h05, 32'd0, lat, err, rd, ne);
        n_tests++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'd0 || ne !== 0) begin
            n_fail++;
            $display("FAIL misaligned_word_load: lat=%0d err=%b rdata=%h ena_cycles=%0d, expected 1 1 0 0",
                     lat, err, rd, ne);
        end
        do_req(1'b1, 2'b01, 1'b0, 7'h03, 32'h0000_5555, lat, err, rd, ne);
        n_tests++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'd0 || ne !== 0) begin
            n_fail++;
            $display("FAIL misaligned_half_store: lat=%0d err=%b rdata=%h ena_cycles=%0d, expected 1 1 0 0",
                     lat, err, rd, ne);
        end
        n_tests++;
        if (mem[0] !== 32'h0BAD_F00D || n_wr !== wr0) begin
            n_fail++;
            $display("FAIL misaligned_ram: RAM[0]=%h writes=%0d, expected 0badf00d and 0 writes", mem[0], n_wr - wr0);
        end
        do_req(1'b0, 2'b11, 1'b0, 7'h00, 32'd0, lat, err, rd, ne);
        n_tests++;
        if (lat !== 1 || err !== 1'b1 || ne !== 0) begin
            n_fail++;
            $display("FAIL reserved_size: lat=%0d err=%b ena_cycles=%0d, expected 1 1 0", lat, err, ne);
        end
    endtask

    task automatic test_reset_rmw();
        int wr0;
        int rsp_seen;
        preload(5'd4, 32'h5566_7788);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 7'h10; req_wdata = 32'h0000_0099;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wr0 = n_wr;
        rsp_seen = 0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (wena !== 1'b1 || addr !== 5'd4) begin
            n_fail++;
            $display("FAIL rmw_reaches_wr: wena=%b addr=%h, expected 1 and 04", wena, addr);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (wena !== 1'b0 || ram_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_gates_wr: wena=%b ena=%b, expected 0 0", wena, ram_ena);
        end
        @(negedge clk);
        if (rsp_valid) rsp_seen++;
        n_tests++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_in_reset: got %b expected 0", req_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        if (rsp_valid) rsp_seen++;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset: got %b expected 1", req_ready);
        end
        @(negedge clk);
        if (rsp_valid) rsp_seen++;
        n_tests++;
        if (rsp_seen !== 0 || n_wr !== wr0 || mem[4] !== 32'h5566_7788) begin
            n_fail++;
            $display("FAIL reset_rmw_abandon: rsp=%0d writes=%0d RAM[4]=%h, expected 0 0 55667788",
                     rsp_seen, n_wr - wr0, mem[4]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rd [3];
        logic [6:0]  req_a  [3];
        int acc_cyc [3];
        int rsp_cyc [3];
        int nacc, nrsp, overlap, bad_rd;
        bit pend;
        exp_rd[0] = 32'hA5A5_0005; req_a[0] = 7'h14;
        exp_rd[1] = 32'hA5A5_0006; req_a[1] = 7'h18;
        exp_rd[2] = 32'hA5A5_0007; req_a[2] = 7'h1C;
        for (int i = 0; i < 3; i++) preload(5'(5 + i), exp_rd[i]);
        nacc = 0; nrsp = 0; overlap = 0; bad_rd = 0; pend = 1'b0;
        for (int i = 0; i < 3; i++) begin
            acc_cyc[i] = -100; rsp_cyc[i] = -100;
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = req_a[0]; req_wdata = 32'd0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (ram_ena && (req_ready || rsp_valid)) overlap++;
            if (rsp_valid) begin
                if (nrsp < 3) begin
                    rsp_cyc[nrsp] = cyc;
                    if (rsp_rdata !== exp_rd[nrsp] || rsp_err !== 1'b0) bad_rd++;
                end
                nrsp++;
            end
            if (pend) begin
                pend = 1'b0;
                if (nacc < 3) req_addr = req_a[nacc];
                else req_valid = 1'b0;
            end
            if (req_valid && req_ready) begin
                if (nacc < 3) acc_cyc[nacc] = cyc;
                nacc++;
                pend = 1'b1;
            end
        end
        req_valid = 1'b0;
        n_tests++;
        if (nacc !== 3 || nrsp !== 3) begin
            n_fail++;
            $display("FAIL b2b_counts: accepted=%0d responses=%0d, expected 3 3", nacc, nrsp);
        end
        n_tests++;
        if (bad_rd !== 0) begin
            n_fail++;
            $display("FAIL b2b_rdata: %0d responses had wrong data or err, expected 0", bad_rd);
        end
        n_tests++;
        if (acc_cyc[1] - acc_cyc[0] !== 4 || acc_cyc[2] - acc_cyc[1] !== 4) begin
            n_fail++;
            $display("FAIL b2b_accept_spacing: accepts at %0d %0d %0d, expected 4-cycle spacing",
                     acc_cyc[0], acc_cyc[1], acc_cyc[2]);
        end
        n_tests++;
        if (rsp_cyc[0] - acc_cyc[0] !== 3 || rsp_cyc[2] - acc_cyc[2] !== 3) begin
            n_fail++;
            $display("FAIL b2b_latency: rsp0=%0d rsp2=%0d after accept, expected 3 3",
                     rsp_cyc[0] - acc_cyc[0], rsp_cyc[2] - acc_cyc[2]);
        end
        n_tests++;
        if (overlap !== 0) begin
            n_fail++;
            $display("FAIL b2b_overlap: %0d cycles with RAM active outside a request, expected 0", overlap);
        end
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        n_wr = 0; n_rd = 0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_signed = 1'b0; req_addr = 7'd0; req_wdata = 32'd0;
        pre_we = 1'b0; pre_addr = 5'd0; pre_data = 32'd0;
        test_reset();
        test_word_store_load();
        test_byte_rmw();
        test_sub_loads();
        test_misaligned();
        test_reset_rmw();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
